// File: rtl/multiplier_pipelined_nbits_if.sv
// multiplier_pipelined_nbits_if: operand/product handshake bundle for the pipelined multiplier
interface multiplier_pipelined_nbits_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic in_signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic out_valid;
  logic out_ready;
  logic [2*WIDTH-1:0] product;
  logic busy;
  modport master (output in_valid, in_signed, A, B, out_ready, input in_ready, out_valid, product, busy);
  modport slave (input in_valid, in_signed, A, B, out_ready, output in_ready, out_valid, product, busy);
endinterface

// File: rtl/multiplier_pipelined_nbits.sv
// multiplier_pipelined_nbits: 3-stage signed/unsigned multiplier, Baugh-Wooley + Dadda + Kogge-Stone
module multiplier_pipelined_nbits #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  multiplier_pipelined_nbits_if.slave bus
);
  localparam int P = 2 * WIDTH;
  logic v1, v2, s1, adv1, adv2, adv3;
  logic [WIDTH-1:0] a1, b1;
  logic [P-1:0] row0, row1, r0, r1, sum;
  always_comb begin
    adv3 = !bus.out_valid || bus.out_ready;
    adv2 = !v2 || adv3;
    adv1 = !v1 || adv2;
  end
  assign bus.in_ready = adv1;
  assign bus.busy = v1 | v2 | bus.out_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.product <= '0;
    end else begin
      if (adv1) v1 <= bus.in_valid;
      if (adv2) v2 <= v1;
      if (adv3) bus.out_valid <= v2;
      if (adv3 && v2) bus.product <= sum;
    end
  always_ff @(posedge clk) begin
    if (adv1 && bus.in_valid) begin
      a1 <= bus.A;
      b1 <= bus.B;
      s1 <= bus.in_signed;
    end
    if (adv2 && v1) begin
      r0 <= row0;
      r1 <= row1;
    end
  end
  // Modified Baugh-Wooley matrix: sign-row/column terms inverted, constant ones at columns WIDTH and P-1
  always_comb begin : dadda
    logic [P-1:0][WIDTH:0] m, nm;
    int h [P];
    int nh [P];
    int d, t, k;
    logic s, c;
    m = '0;
    nm = '0;
    d = 0;
    t = 0;
    k = 0;
    s = 1'b0;
    c = 1'b0;
    row0 = '0;
    row1 = '0;
    for (int i = 0; i < P; i++) begin
      h[i] = 0;
      nh[i] = 0;
    end
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++) begin
        m[i+j][h[i+j]] = (a1[i] & b1[j]) ^ (s1 & ((i == WIDTH-1) != (j == WIDTH-1)));
        h[i+j]++;
      end
    m[WIDTH][h[WIDTH]] = s1;
    h[WIDTH]++;
    m[P-1][h[P-1]] = s1;
    h[P-1]++;
    // Dadda targets 63,42,...,3,2; a column is only compressed down to the current target
    for (int j = 9; j >= 0; j--) begin
      d = 2;
      for (int q = 0; q < j; q++) d = d * 3 / 2;
      nm = '0;
      for (int i = 0; i < P; i++) nh[i] = 0;
      for (int i = 0; i < P; i++) begin
        k = 0;
        t = h[i] + nh[i];
        for (int r = 0; r < WIDTH; r++)
          if (t > d) begin
            if (t == d + 1) begin
              s = m[i][k] ^ m[i][k+1];
              c = m[i][k] & m[i][k+1];
              k = k + 2;
              t = t - 1;
            end else begin
              s = m[i][k] ^ m[i][k+1] ^ m[i][k+2];
              c = (m[i][k] & m[i][k+1]) | (m[i][k+2] & (m[i][k] ^ m[i][k+1]));
              k = k + 3;
              t = t - 2;
            end
            nm[i][nh[i]] = s;
            nh[i]++;
            if (i < P - 1) begin
              nm[i+1][nh[i+1]] = c;
              nh[i+1]++;
            end
          end
        for (int r = 0; r <= WIDTH; r++)
          if (k < h[i]) begin
            nm[i][nh[i]] = m[i][k];
            nh[i]++;
            k++;
          end
      end
      m = nm;
      for (int i = 0; i < P; i++) h[i] = nh[i];
    end
    for (int i = 0; i < P; i++) begin
      row0[i] = m[i][0];
      row1[i] = m[i][1];
    end
  end
  // In-place prefix tree: descending index keeps the lower operand at its previous level
  always_comb begin : kogge_stone
    logic [P-1:0] g, p;
    g = r0 & r1;
    p = r0 ^ r1;
    for (int s = 1; s < P; s = s * 2)
      for (int i = P - 1; i >= s; i--) begin
        g[i] = g[i] | (p[i] & g[i-s]);
        p[i] = p[i] & p[i-s];
      end
    sum = r0 ^ r1 ^ {g[P-2:0], 1'b0};
  end
endmodule
